// File: rtl/bitslice_alu_p.sv
// Parametrised 2901-class bit-slice ALU: register file, Q register, shift pins, lookahead flags.
// Define BITSLICE_MUL_EN to build the START/BUSY/DONE unsigned multiply sequencer.
module bitslice_alu_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 16,
    parameter int unsigned AW    = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [8:0]       I,
    input  logic [AW-1:0]    AADD,
    input  logic [AW-1:0]    BADD,
    input  logic [WIDTH-1:0] D,
    input  logic             C0,
    input  logic             OEBAR,
    output logic [WIDTH-1:0] Y,
    inout  wire              RAM0,
    inout  wire              RAMN,
    inout  wire              Q0,
    inout  wire              QN,
    output logic             CO,
    output logic             GBAR,
    output logic             PBAR,
    output logic             OVR,
    output logic             FN,
    output logic             FZ,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] r_ram [NREG];
    logic [WIDTH-1:0] r_q;

    logic [2:0]       w_src;
    logic [2:0]       w_fn;
    logic [2:0]       w_dst;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_re;
    logic [WIDTH-1:0] w_se;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_y;
    logic             w_arith;
    logic             w_cin_msb;
    logic             w_p;
    logic             w_g;
    logic             w_ram_we;
    logic             w_q_we;
    logic [WIDTH-1:0] w_ram_wd;
    logic [WIDTH-1:0] w_q_wd;
    logic             w_busy;

    assign w_src = I[2:0];
    assign w_fn  = I[5:3];
    assign w_dst = I[8:6];

    assign w_a = r_ram[AADD];
    assign w_b = r_ram[BADD];

    always_comb begin
        w_r = '0;
        w_s = '0;
        case (w_src)
            3'd0: begin w_r = w_a; w_s = r_q; end
            3'd1: begin w_r = w_a; w_s = w_b; end
            3'd2: begin w_r = '0;  w_s = r_q; end
            3'd3: begin w_r = '0;  w_s = w_b; end
            3'd4: begin w_r = '0;  w_s = w_a; end
            3'd5: begin w_r = D;   w_s = w_a; end
            3'd6: begin w_r = D;   w_s = r_q; end
            3'd7: begin w_r = D;   w_s = '0;  end
        endcase
    end

    // Effective operands feed both the adder and the lookahead terms.
    assign w_arith   = (w_fn < 3'd3);
    assign w_re      = (w_fn == 3'd1) ? ~w_r : w_r;
    assign w_se      = (w_fn == 3'd2) ? ~w_s : w_s;
    assign w_sum     = {1'b0, w_re} + {1'b0, w_se} + {{WIDTH{1'b0}}, C0};
    assign w_cin_msb = w_sum[WIDTH-1] ^ w_re[WIDTH-1] ^ w_se[WIDTH-1];

    always_comb begin
        w_f = w_sum[WIDTH-1:0];
        case (w_fn)
            3'd3:    w_f = w_r | w_s;
            3'd4:    w_f = w_r & w_s;
            3'd5:    w_f = ~w_r & w_s;
            3'd6:    w_f = w_r ^ w_s;
            3'd7:    w_f = ~(w_r ^ w_s);
            default: w_f = w_sum[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_g = w_re[0] & w_se[0];
        for (int k = 1; k < WIDTH; k++) begin
            w_g = (w_re[k] & w_se[k]) | ((w_re[k] | w_se[k]) & w_g);
        end
    end
    assign w_p = &(w_re | w_se);

    assign CO   = w_arith & w_sum[WIDTH];
    assign OVR  = w_arith & (w_cin_msb ^ w_sum[WIDTH]);
    assign FN   = w_f[WIDTH-1];
    assign FZ   = (w_f == '0);
    assign GBAR = ~w_g;
    assign PBAR = ~w_p;

    assign w_y = (w_dst == 3'd2) ? w_a : w_f;
    assign Y   = OEBAR ? {WIDTH{1'bz}} : w_y;

    assign RAM0 = (w_dst == 3'd4 || w_dst == 3'd5) ? w_f[0] : 1'bz;
    assign Q0   = (w_dst == 3'd4) ? r_q[0] : 1'bz;
    assign RAMN = (w_dst == 3'd6 || w_dst == 3'd7) ? w_f[WIDTH-1] : 1'bz;
    assign QN   = (w_dst == 3'd6) ? r_q[WIDTH-1] : 1'bz;

    always_comb begin
        w_ram_we = 1'b0;
        w_q_we   = 1'b0;
        w_ram_wd = w_f;
        w_q_wd   = w_f;
        case (w_dst)
            3'd0: w_q_we = 1'b1;
            3'd1: ;
            3'd2, 3'd3: w_ram_we = 1'b1;
            3'd4: begin
                w_ram_we = 1'b1;
                w_ram_wd = {RAMN, w_f[WIDTH-1:1]};
                w_q_we   = 1'b1;
                w_q_wd   = {QN, r_q[WIDTH-1:1]};
            end
            3'd5: begin
                w_ram_we = 1'b1;
                w_ram_wd = {RAMN, w_f[WIDTH-1:1]};
            end
            3'd6: begin
                w_ram_we = 1'b1;
                w_ram_wd = {w_f[WIDTH-2:0], RAM0};
                w_q_we   = 1'b1;
                w_q_wd   = {r_q[WIDTH-2:0], Q0};
            end
            3'd7: begin
                w_ram_we = 1'b1;
                w_ram_wd = {w_f[WIDTH-2:0], RAM0};
            end
        endcase
    end

`ifdef BITSLICE_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} mul_state_e;

    mul_state_e       r_state;
    mul_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_badd;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_q;

    // Shift-add step: {c,ACC} = ACC + (Q[0] ? MC : 0), then {c,ACC,Q} >> 1.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mc} : '0);
    assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        case (r_state)
            StIdle: begin
                if (START) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = CW'(WIDTH);
                    w_acc_nxt   = '0;
                end
            end
            StRun: begin
                w_acc_nxt = w_mul_sum[WIDTH:1];
                w_cnt_nxt = r_cnt - CW'(1);
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = StFin;
                end
            end
            StFin:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_mc    <= '0;
            r_cnt   <= '0;
            r_badd  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == StIdle && START) begin
                r_mc   <= w_a;
                r_badd <= BADD;
            end
        end
    end

    assign w_busy = (r_state != StIdle);
    assign BUSY   = w_busy;
    assign DONE   = (r_state == StFin);
`else
    logic w_unused_start;
    assign w_unused_start = START;
    assign w_busy         = 1'b0;
    assign BUSY           = 1'b0;
    assign DONE           = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NREG; k++) begin
                r_ram[k] <= '0;
            end
            r_q <= '0;
        end else begin
            if (w_ram_we && !w_busy) begin
                r_ram[BADD] <= w_ram_wd;
            end
            if (w_q_we && !w_busy) begin
                r_q <= w_q_wd;
            end
`ifdef BITSLICE_MUL_EN
            if (r_state == StRun) begin
                r_q <= w_mul_q;
            end
            if (r_state == StFin) begin
                r_ram[r_badd] <= r_acc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bitslice_alu_p.sv
// Self-checking bench for bitslice_alu_p (WIDTH=8, NREG=16); multiply tests need BITSLICE_MUL_EN.
module tb_bitslice_alu_p;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic [8:0] I     = 9'b001_011_001;
    logic [3:0] AADD  = 4'd0;
    logic [3:0] BADD  = 4'd0;
    logic [7:0] D     = 8'h00;
    logic       C0    = 1'b0;
    logic       OEBAR = 1'b0;
    logic       START = 1'b0;
    logic [7:0] Y;
    logic       CO, GBAR, PBAR, OVR, FN, FZ, BUSY, DONE;

    logic tb_ram0_en = 1'b0, tb_ram0_v = 1'b0;
    logic tb_ramn_en = 1'b0, tb_ramn_v = 1'b0;
    logic tb_q0_en   = 1'b0, tb_q0_v   = 1'b0;
    logic tb_qn_en   = 1'b0, tb_qn_v   = 1'b0;
    wire  pin_ram0, pin_ramn, pin_q0, pin_qn;

    assign pin_ram0 = tb_ram0_en ? tb_ram0_v : 1'bz;
    assign pin_ramn = tb_ramn_en ? tb_ramn_v : 1'bz;
    assign pin_q0   = tb_q0_en   ? tb_q0_v   : 1'bz;
    assign pin_qn   = tb_qn_en   ? tb_qn_v   : 1'bz;

    bitslice_alu_p #(.WIDTH(8), .NREG(16)) dut (
        .CLK(CLK), .RST(RST), .I(I), .AADD(AADD), .BADD(BADD), .D(D), .C0(C0),
        .OEBAR(OEBAR), .Y(Y), .RAM0(pin_ram0), .RAMN(pin_ramn), .Q0(pin_q0), .QN(pin_qn),
        .CO(CO), .GBAR(GBAR), .PBAR(PBAR), .OVR(OVR), .FN(FN), .FZ(FZ),
        .START(START), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [8:0] i;
        logic [3:0] aadd;
        logic [3:0] badd;
        logic [7:0] d;
        logic       c0;
        logic [7:0] y;
        logic       co;
        logic       ovr;
        logic       fn;
        logic       fz;
        logic       pg;
        logic       gbar;
        logic       pbar;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] v);
        I = 9'b011_000_111; D = v; BADD = a; C0 = 1'b0;
        step();
    endtask

    task automatic loadq(input logic [7:0] v);
        I = 9'b000_011_111; D = v; C0 = 1'b0;
        step();
    endtask

    task automatic read_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        I = 9'b001_011_100; AADD = a;
        #1;
        chk(name, Y, exp);
        step();
    endtask

    task automatic read_q(input string name, input logic [7:0] exp);
        I = 9'b001_011_010;
        #1;
        chk(name, Y, exp);
        step();
    endtask

`ifdef BITSLICE_MUL_EN
    task automatic run_mul(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        int nbusy;
        int ndone;
        int done_at;
        nbusy = 0; ndone = 0; done_at = 0;
        I = 9'b001_011_001; AADD = 4'd3; BADD = 4'd4; START = 1'b1;
        step();
        // A Q write and a changed BADD while busy must both be ignored.
        START = 1'b0; I = 9'b000_011_111; D = 8'hAA; BADD = 4'd7;
        #1;
        chk({tag, "_y_follows_i"}, Y, 8'hAA);
        for (int k = 1; k <= 20; k++) begin
            if (!BUSY) break;
            nbusy++;
            if (DONE) begin
                ndone++;
                done_at = k;
            end
            step();
        end
        I = 9'b001_011_001;
        chk({tag, "_busy_cycles"}, nbusy, 9);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_done_cycle"}, done_at, 9);
        read_reg({tag, "_hi"}, 4'd4, hi);
        read_q({tag, "_lo"}, lo);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        //             i             aa    ba    d      c0    y      co ovr fn fz pg gb pb
        vecs[0]  = '{9'b001_000_000, 4'd1, 4'd0, 8'h00, 1'b0, 8'hBB, 0, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{9'b001_000_001, 4'd2, 4'd2, 8'h00, 1'b0, 8'h02, 1, 1, 0, 0, 1, 0, 1};
        vecs[2]  = '{9'b001_010_010, 4'd0, 4'd0, 8'h00, 1'b1, 8'hC4, 0, 0, 1, 0, 0, 0, 0};
        vecs[3]  = '{9'b001_011_011, 4'd0, 4'd1, 8'h00, 1'b1, 8'h7F, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{9'b001_100_100, 4'd1, 4'd0, 8'h00, 1'b1, 8'h00, 0, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{9'b001_101_101, 4'd2, 4'd0, 8'h0F, 1'b0, 8'h80, 0, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{9'b001_110_110, 4'd0, 4'd0, 8'hFF, 1'b0, 8'hC3, 0, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{9'b001_111_111, 4'd0, 4'd0, 8'hFF, 1'b0, 8'h00, 0, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{9'b001_000_111, 4'd0, 4'd0, 8'hFF, 1'b1, 8'h00, 1, 0, 0, 1, 1, 1, 0};
        vecs[9]  = '{9'b001_001_001, 4'd1, 4'd2, 8'h00, 1'b1, 8'h02, 1, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{9'b010_011_111, 4'd1, 4'd9, 8'h55, 1'b0, 8'h7F, 0, 0, 0, 0, 0, 0, 0};

        step();
        RST = 1'b0;
        I = 9'b001_011_001; AADD = 4'd5; BADD = 4'd5;
        #1;
        chk("rst_y", Y, 8'h00);
        chk("rst_fz", FZ, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);

        load(4'd1, 8'h7F);
        I = 9'b001_000_101; D = 8'h01; AADD = 4'd1; C0 = 1'b0;
        #1;
        chk("add_ovr_y", Y, 8'h80);
        chk("add_ovr_ovr", OVR, 1'b1);
        chk("add_ovr_co", CO, 1'b0);
        chk("add_ovr_fn", FN, 1'b1);

        load(4'd2, 8'h05);
        I = 9'b001_001_101; D = 8'h05; AADD = 4'd2; C0 = 1'b1;
        #1;
        chk("sub_zero_y", Y, 8'h00);
        chk("sub_zero_fz", FZ, 1'b1);
        chk("sub_zero_co", CO, 1'b1);
        chk("sub_zero_ovr", OVR, 1'b0);

        load(4'd2, 8'h02);
        tb_ramn_en = 1'b1; tb_ramn_v = 1'b1;
        I = 9'b101_011_011; BADD = 4'd2; C0 = 1'b0;
        #1;
        chk("ramd_ram0_pin", pin_ram0, 1'b0);
        step();
        tb_ramn_en = 1'b0;
        read_reg("ramd_result", 4'd2, 8'h81);

        loadq(8'h3C);
        for (int v = 0; v < 11; v++) begin
            I = vecs[v].i; AADD = vecs[v].aadd; BADD = vecs[v].badd;
            D = vecs[v].d; C0 = vecs[v].c0;
            #1;
            chk($sformatf("vec%0d_y", v), Y, vecs[v].y);
            chk($sformatf("vec%0d_co", v), CO, vecs[v].co);
            chk($sformatf("vec%0d_ovr", v), OVR, vecs[v].ovr);
            chk($sformatf("vec%0d_fn", v), FN, vecs[v].fn);
            chk($sformatf("vec%0d_fz", v), FZ, vecs[v].fz);
            if (vecs[v].pg) begin
                chk($sformatf("vec%0d_gbar", v), GBAR, vecs[v].gbar);
                chk($sformatf("vec%0d_pbar", v), PBAR, vecs[v].pbar);
            end
            step();
        end

        // Same-cycle write then read: old value before the edge, new value after.
        I = 9'b010_000_111; D = 8'h11; AADD = 4'd9; BADD = 4'd9; C0 = 1'b0;
        #1;
        chk("rd_old", Y, 8'h55);
        step();
        chk("rd_new", Y, 8'h11);

        tb_ramn_en = 1'b1; tb_ramn_v = 1'b0; tb_qn_en = 1'b1; tb_qn_v = 1'b1;
        I = 9'b100_011_011; AADD = 4'd0; BADD = 4'd9;
        #1;
        chk("dn_ram0_pin", pin_ram0, 1'b1);
        chk("dn_q0_pin", pin_q0, 1'b0);
        step();
        tb_ramn_en = 1'b0; tb_qn_en = 1'b0;
        read_reg("dn_ram", 4'd9, 8'h08);
        read_q("dn_q", 8'h9E);

        tb_ram0_en = 1'b1; tb_ram0_v = 1'b1; tb_q0_en = 1'b1; tb_q0_v = 1'b0;
        I = 9'b110_011_011; BADD = 4'd9;
        #1;
        chk("up_ramn_pin", pin_ramn, 1'b0);
        chk("up_qn_pin", pin_qn, 1'b1);
        step();
        tb_ram0_en = 1'b0; tb_q0_en = 1'b0;
        read_reg("up_ram", 4'd9, 8'h11);
        read_q("up_q", 8'h3C);

        tb_ram0_en = 1'b1; tb_ram0_v = 1'b0; tb_q0_en = 1'b1; tb_q0_v = 1'b1;
        I = 9'b111_011_011; BADD = 4'd9;
        step();
        tb_ram0_en = 1'b0; tb_q0_en = 1'b0;
        read_reg("up7_ram", 4'd9, 8'h22);
        read_q("up7_q_kept", 8'h3C);

`ifdef BITSLICE_MUL_EN
        load(4'd3, 8'd13);
        loadq(8'd11);
        run_mul("mul13x11", 8'h00, 8'h8F);

        load(4'd3, 8'hFF);
        loadq(8'hFF);
        run_mul("mulffxff", 8'hFE, 8'h01);

        load(4'd3, 8'd13);
        loadq(8'd11);
        I = 9'b001_011_001; AADD = 4'd3; BADD = 4'd4; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        step();
        chk("abort_busy_before", BUSY, 1'b1);
        RST = 1'b1;
        step();
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_done", DONE, 1'b0);
        RST = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (DONE) ndone++;
            step();
        end
        chk("abort_no_done", ndone, 0);
        read_reg("abort_ram4", 4'd4, 8'h00);
        read_q("abort_q", 8'h00);
`else
        I = 9'b001_011_001; AADD = 4'd3; BADD = 4'd4; START = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("nomul_busy%0d", k), BUSY, 1'b0);
            chk($sformatf("nomul_done%0d", k), DONE, 1'b0);
            step();
        end
        read_q("nomul_q_kept", 8'h3C);
`endif

        load(4'd1, 8'hA5);
        loadq(8'h5A);
        RST = 1'b1;
        step();
        RST = 1'b0;
        read_reg("final_rst_ram1", 4'd1, 8'h00);
        read_q("final_rst_q", 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bitslice_alu_p.md
# bitslice_alu_p

Parametrised successor to the 4-bit 2901-class bit-slice ALU. Keeps the 9-bit microinstruction encoding (source / function / destination), the dual-port register file, the Q register, the tristate shift pins and the carry-lookahead outputs. Adds:
- configurable data width and register count;
- a synchronous reset;
- an optional multi-cycle unsigned multiply sequencer with a START/BUSY/DONE handshake.

It sits in the datapath between the microsequencer and the system bus.

## Interface
Parameters:
- WIDTH, 8: data width in bits (≥4).
- NREG, 16: register-file depth (power of two ≥2).
- AW, $clog2(NREG): register address width.

Ports:
- CLK  input  1  clock, all state updates on posedge CLK.
- RST  input  1  reset, synchronous, active-high.
- I  input  9  microinstruction: I[2:0] source, I[5:3] function, I[8:6] destination.
- AADD, BADD  input  AW  register-file A and B addresses.
- D  input  WIDTH  direct data operand.
- C0  input  1  carry in.
- OEBAR  input  1  Y output enable, active-low.
- Y  output  WIDTH  data out; all-z when OEBAR=1.
- RAM0, RAMN  inout  1  register shifter LSB and MSB pins.
- Q0, QN  inout  1  Q shifter LSB and MSB pins.
- CO, GBAR, PBAR, OVR, FN, FZ  output  1 each:
  - CO: carry out.
  - GBAR, PBAR: lookahead generate and propagate (active-low).
  - OVR: signed overflow.
  - FN: F[WIDTH-1].
  - FZ: F==0.
- START  input  1  multiply request.
- BUSY  output  1  sequencer active.
- DONE  output  1  one-cycle completion pulse.

## Operation
Operand reads and ALU:
- A=RAM[AADD] and B=RAM[BADD] are combinational reads.
- Source field I[2:0] selects (R,S):
  - 0: (A,Q)
  - 1: (A,B)
  - 2: (0,Q)
  - 3: (0,B)
  - 4: (0,A)
  - 5: (D,A)
  - 6: (D,Q)
  - 7: (D,0)
- Function field I[5:3]:
  - 0: R+S+C0
  - 1: S+~R+C0
  - 2: R+~S+C0
  - 3: R|S
  - 4: R&S
  - 5: ~R&S
  - 6: R^S
  - 7: ~(R^S)
- Arithmetic is computed at WIDTH+1 bits; CO is bit WIDTH.
- OVR = carry into MSB xor CO.
- For logic functions (3–7), CO=0 and OVR=0.
- P and G are bitwise OR/AND of the effective (possibly inverted) operands, reduced across all WIDTH bits in standard lookahead form.

Destination field I[8:6]:
- 0: Q←F; Y=F.
- 1: no write; Y=F.
- 2: RAM[BADD]←F; Y=A.
- 3: RAM[BADD]←F; Y=F.
- 4: RAM←{RAMN,F[W-1:1]} and Q←{QN,Q[W-1:1]}.
- 5: RAM shift-down only; Q unchanged.
- 6: RAM←{F[W-2:0],RAM0} and Q←{Q[W-2:0],Q0}.
- 7: RAM shift-up only; Q unchanged.
- Destinations 4–7 drive Y=F.

Shift pin drivers:
- Down (4,5): drive RAM0=F[0], and Q0=Q[0] only for code 4. RAMN and QN are inputs.
- Up (6,7): drive RAMN=F[W-1], and QN=Q[W-1] only for code 6. RAM0 and Q0 are inputs.
- Any pin not driven is z.

Multiply sequencer (compiled in only with the macro):
- States: IDLE → RUN → FIN → IDLE.
- IDLE & START: latch MC=A, latch BADD, clear ACC, set count=WIDTH, go to RUN. The multiplier is the current Q.
- RUN, each cycle:
  - {c,ACC} = ACC + (Q[0] ? MC : 0).
  - {ACC,Q} = {c,ACC,Q}>>1.
  - count decrements; at 0 go to FIN.
- FIN: RAM[latched BADD]←ACC (high half); DONE=1 for this cycle; Q holds the low half; go to IDLE.
- BUSY=1 in RUN and FIN.
- While BUSY: I-driven writes to RAM and Q are suppressed, START is ignored, and the combinational outputs still follow I.

Reset:
- RST=1 clears every RAM entry and Q, and forces IDLE, BUSY=0, DONE=0.
- Reset overrides everything, including a multiply in progress (aborted, no DONE).
- Outputs after reset follow from the zeroed state; Y is z if OEBAR=1.

## Timing
- ALU, Y, flags and shift-pin drivers are combinational from I, addresses, D, C0, OEBAR and the current state.
- RAM and Q update on the posedge following the instruction.
- A read of a location written in the same cycle returns the old value.
- Multiply: START is sampled at edge 0; BUSY is high from edge 0 through edge WIDTH+1; DONE is high in cycle WIDTH+1; the product is visible in cycle WIDTH+2.
- START held high in IDLE the cycle after DONE starts a new multiply.

## Configuration
- BITSLICE_MUL_EN defined: the sequencer, START/BUSY/DONE behaviour and the ACC/MC/count registers are present.
- BITSLICE_MUL_EN undefined:
  - the ports remain;
  - START is ignored;
  - BUSY=0 and DONE=0 constantly;
  - no sequencer logic is synthesised.

## Test plan
All scenarios use WIDTH=8, NREG=16, OEBAR=0.
1. RST for 1 cycle, then I=9'b001_011_001 (NOP, R|S, (A,B)), AADD=BADD=5 → Y=0x00, FZ=1, BUSY=0, DONE=0.
2. Load RAM[1]=0x7F via I=011_000_111 with D=0x7F, C0=0. Then I=001_000_101, D=0x01, AADD=1 → F=0x80, OVR=1, CO=0, FN=1.
3. With RAM[2]=0x05, I=001_001_101, D=0x05, AADD=2, C0=1 → F=0x00, FZ=1, CO=1, OVR=0.
4. With RAM[2]=0x02, I=101_011_011 (RAMD, R|S, (0,B)), BADD=2, RAMN driven 1 → RAM0 pin=0; next cycle RAM[2]=0x81.
5. (MUL_EN) RAM[3]=13, Q=11, AADD=3, BADD=4, START pulse → BUSY for 9 cycles, single DONE; afterwards RAM[4]=0x00, Q=0x8F. Repeat with 0xFF×0xFF → RAM[4]=0xFE, Q=0x01.
6. (MUL_EN) RST asserted in the 4th RUN cycle → BUSY=0 next cycle, no DONE, Q=0, RAM[4]=0.
